// File: rtl/y_arith_pkg.sv
// y_arith_pkg -- shared constants and helpers for the pipelined adder/subtractor.
//   OP_ADD / OP_SUB        : encodings of the op-select input c
//   DEF_WIDTH / DEF_STAGES : default operand width and pipeline depth
//   slice_width()          : bits handled by each pipeline slice
//   sat_max() / sat_min()  : signed saturation limits, returned in a wide
//                            vector that callers truncate to their width
// Optional feature macro used by the pipeline: Y_ARITH_SAT_EN.
package y_arith_pkg;

    localparam logic OP_ADD     = 1'b0;
    localparam logic OP_SUB     = 1'b1;

    localparam int   DEF_WIDTH  = 32;
    localparam int   DEF_STAGES = 4;

    // Widest operand the saturation helpers can describe.
    localparam int   MAX_WIDTH  = 128;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

    // 2^(width-1)-1: (width-1) ones in the low bits.
    function automatic logic [MAX_WIDTH-1:0] sat_max(input int width);
        return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width + 1);
    endfunction

    // -2^(width-1) in width-bit two's complement: only the sign bit set.
    function automatic logic [MAX_WIDTH-1:0] sat_min(input int width);
        return {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
    endfunction

endpackage

// File: rtl/y_arith_slice.sv
// y_arith_slice -- purely combinational SW-bit adder slice with carry in/out.
//   a, b : SW-bit slice operands (b already inverted for subtract)
//   cin  : carry into the slice LSB
//   sum  : SW-bit slice sum
//   cout : carry out of the slice MSB
module y_arith_slice #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout
);

    logic [SW:0] total_s;

    // One extra bit on the sum captures the slice carry-out.
    always_comb begin
        total_s = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
    end

    assign sum  = total_s[SW-1:0];
    assign cout = total_s[SW];

endmodule

// File: rtl/y_arith_pipe.sv
// y_arith_pipe -- pipelined WIDTH-bit adder/subtractor, one carry slice per stage.
//   clk, reset_n        : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready : operand beat handshake (in_ready = not stalled)
//   a, b, c             : signed operands; c selects add (0) or subtract (1)
//   out_valid/out_ready : result handshake with full backpressure
//   z, cout, ovf        : registered result, raw MSB carry, signed overflow
// Optional: with Y_ARITH_SAT_EN defined an extra input 'sat' travels with the
// beat and clamps z to the signed limits when the beat overflows.
// WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH.
module y_arith_pipe
    import y_arith_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
`ifdef Y_ARITH_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf
);

    localparam int SW   = slice_width(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

`ifdef Y_ARITH_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));
`endif

    // Stage registers: entry k holds the beat after slice k has been added.
    logic [STAGES-1:0]            valid_r;
    logic [STAGES-1:0][WIDTH-1:0] a_r;
    logic [STAGES-1:0][WIDTH-1:0] bp_r;
    logic [STAGES-1:0][WIDTH-1:0] z_r;
    logic [STAGES-1:0]            carry_r;
    logic                         ovf_r;

    // Per-stage inputs (previous register, or the ports for stage 0) and results.
    logic [STAGES-1:0]            valid_s;
    logic [STAGES-1:0][WIDTH-1:0] a_s;
    logic [STAGES-1:0][WIDTH-1:0] bp_s;
    logic [STAGES-1:0][WIDTH-1:0] zsrc_s;
    logic [STAGES-1:0][WIDTH-1:0] znext_s;
    logic [STAGES-1:0][WIDTH-1:0] zreg_s;
    logic [STAGES-1:0]            cin_s;
    logic [STAGES-1:0]            carry_s;
    logic [STAGES-1:0][SW-1:0]    sum_s;

`ifdef Y_ARITH_SAT_EN
    logic [STAGES-1:0]            sat_r;
    logic [STAGES-1:0]            sat_s;
`endif

    logic [WIDTH-1:0]             bp_in_s;
    logic [WIDTH-1:0]             zfinal_s;
    logic                         ovf_s;
    logic                         stall_s;
    logic                         advance_s;

    // A single global stall freezes every stage; bubbles never collapse.
    assign stall_s   = valid_r[LAST] & ~out_ready;
    assign advance_s = ~stall_s;
    assign in_ready  = ~stall_s;

    // Subtract is a + ~b + 1: invert b here, the +1 enters as slice-0 carry-in.
    always_comb begin
        bp_in_s = b;
        case (c)
            OP_ADD:  bp_in_s = b;
            OP_SUB:  bp_in_s = ~b;
            default: bp_in_s = b;
        endcase
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SW{1'b1}}) << (k * SW);

        if (k == 0) begin : g_head
            assign valid_s[k] = in_valid;
            assign a_s[k]     = a;
            assign bp_s[k]    = bp_in_s;
            assign zsrc_s[k]  = {WIDTH{1'b0}};
            assign cin_s[k]   = c;
`ifdef Y_ARITH_SAT_EN
            assign sat_s[k]   = sat;
`endif
        end else begin : g_body
            assign valid_s[k] = valid_r[k-1];
            assign a_s[k]     = a_r[k-1];
            assign bp_s[k]    = bp_r[k-1];
            assign zsrc_s[k]  = z_r[k-1];
            assign cin_s[k]   = carry_r[k-1];
`ifdef Y_ARITH_SAT_EN
            assign sat_s[k]   = sat_r[k-1];
`endif
        end

        y_arith_slice #(
            .SW (SW)
        ) u_slice (
            .a    (a_s[k][k*SW +: SW]),
            .b    (bp_s[k][k*SW +: SW]),
            .cin  (cin_s[k]),
            .sum  (sum_s[k]),
            .cout (carry_s[k])
        );

        // Lower result bits ride along; this stage fills in its own slice.
        assign znext_s[k] = (zsrc_s[k] & ~SLICE_MASK) | (WIDTH'(sum_s[k]) << (k * SW));

        if (k == LAST) begin : g_tail
            assign zreg_s[k] = zfinal_s;
        end else begin : g_mid
            assign zreg_s[k] = znext_s[k];
        end
    end

    // Overflow (and optional clamp) is resolved in the last slice, once z's sign is known.
    always_comb begin
        ovf_s    = (a_s[LAST][WIDTH-1] == bp_s[LAST][WIDTH-1]) &&
                   (znext_s[LAST][WIDTH-1] != a_s[LAST][WIDTH-1]);
        zfinal_s = znext_s[LAST];
`ifdef Y_ARITH_SAT_EN
        if (sat_s[LAST] && ovf_s) begin
            if (a_s[LAST][WIDTH-1]) begin
                zfinal_s = SAT_MIN;
            end else begin
                zfinal_s = SAT_MAX;
            end
        end else begin
            zfinal_s = znext_s[LAST];
        end
`endif
    end

    // Pipeline registers: cleared by reset, loaded only when not stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= {STAGES{1'b0}};
            a_r     <= {(STAGES*WIDTH){1'b0}};
            bp_r    <= {(STAGES*WIDTH){1'b0}};
            z_r     <= {(STAGES*WIDTH){1'b0}};
            carry_r <= {STAGES{1'b0}};
            ovf_r   <= 1'b0;
        end else if (advance_s) begin
            valid_r <= valid_s;
            a_r     <= a_s;
            bp_r    <= bp_s;
            z_r     <= zreg_s;
            carry_r <= carry_s;
            ovf_r   <= ovf_s;
        end
    end

`ifdef Y_ARITH_SAT_EN
    // Saturation request travels with its beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_r <= {STAGES{1'b0}};
        end else if (advance_s) begin
            sat_r <= sat_s;
        end
    end
`endif

    assign out_valid = valid_r[LAST];
    assign z         = z_r[LAST];
    assign cout      = carry_r[LAST];
    assign ovf       = ovf_r;

endmodule
